// File: rtl/sensor_scan_pkg.sv
// sensor_scan_pkg: shared state encoding and default parameter values for the sensor scan sequencer
package sensor_scan_pkg;
    localparam int DEF_NUM_SENSORS    = 12;
    localparam int DEF_SEL_W          = 4;
    localparam int DEF_DELAY_CYCLES   = 10000;
    localparam int DEF_TIMEOUT_CYCLES = 65535;
    typedef enum logic [2:0] {IDLE, TRIGGER, WAIT_DONE, DELAY, COMPLETE} state_t;
endpackage

// File: rtl/sensor_scan_if.sv
// sensor_scan_if: request/detector handshake and status bundle of the sensor scan sequencer
interface sensor_scan_if import sensor_scan_pkg::*; #(
    parameter int NUM_SENSORS = DEF_NUM_SENSORS,
    parameter int SEL_W       = DEF_SEL_W
) ();
    logic                   startSelector;
    logic                   abort;
    logic [NUM_SENSORS-1:0] sensorMask;
    logic                   detectionComplete;
    logic                   startDetection;
    logic [SEL_W-1:0]       sensorSelect;
    logic                   selectorComplete;
    logic                   busy;
    logic [NUM_SENSORS-1:0] timeoutFlags;
    modport master (
        output startSelector, abort, sensorMask, detectionComplete,
        input  startDetection, sensorSelect, selectorComplete, busy, timeoutFlags
    );
    modport slave (
        input  startSelector, abort, sensorMask, detectionComplete,
        output startDetection, sensorSelect, selectorComplete, busy, timeoutFlags
    );
endinterface

// File: rtl/sensor_next_finder.sv
// sensor_next_finder: lowest enabled channel strictly above from (or lowest overall when first)
module sensor_next_finder import sensor_scan_pkg::*; #(
    parameter int NUM_SENSORS = DEF_NUM_SENSORS,
    parameter int SEL_W       = DEF_SEL_W
) (
    input  logic [NUM_SENSORS-1:0] mask,
    input  logic [SEL_W-1:0]       from,
    input  logic                   first,
    output logic [SEL_W-1:0]       idx,
    output logic                   found
);
    // Walk downward so the lowest qualifying channel is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--)
            if (mask[i] && (first || i > int'(from))) begin
                idx   = SEL_W'(i);
                found = 1'b1;
            end
    end
endmodule

// File: rtl/sensor_scan_sequencer.sv
// sensor_scan_sequencer: steps detection through enabled sensor channels with timeout and inter-channel delay
module sensor_scan_sequencer import sensor_scan_pkg::*; #(
    parameter int NUM_SENSORS    = DEF_NUM_SENSORS,
    parameter int SEL_W          = DEF_SEL_W,
    parameter int DELAY_CYCLES   = DEF_DELAY_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic         clk,
    input logic         reset,
    sensor_scan_if.slave bus
);
    localparam int DW = (DELAY_CYCLES < 1) ? 1 : $clog2(DELAY_CYCLES + 1);
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DLAST = DW'((DELAY_CYCLES == 0) ? 0 : DELAY_CYCLES - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                 state, nxt;
    logic [NUM_SENSORS-1:0] mask_q, flags;
    logic [SEL_W-1:0]       sel, nidx;
    logic [DW-1:0]          dcnt;
    logic [TW-1:0]          tcnt;
    logic                   nfound, start_det, sel_done, busy_q;
    logic                   timed_out, delay_end;

    sensor_next_finder #(.NUM_SENSORS(NUM_SENSORS), .SEL_W(SEL_W)) finder (
        .mask  (state == IDLE ? bus.sensorMask : mask_q),
        .from  (sel),
        .first (state == IDLE),
        .idx   (nidx),
        .found (nfound)
    );

    assign timed_out = tcnt == TLAST;
    assign delay_end = dcnt == DLAST;

    // State register.
    always_ff @(posedge clk)
        state <= reset ? IDLE : nxt;

    // Next-state selection; abort from any active state returns to IDLE.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = bus.startSelector ? (nfound ? TRIGGER : COMPLETE) : IDLE;
            TRIGGER:   nxt = WAIT_DONE;
            WAIT_DONE: nxt = (bus.detectionComplete || timed_out) ? DELAY : WAIT_DONE;
            DELAY:     nxt = delay_end ? (nfound ? TRIGGER : COMPLETE) : DELAY;
            COMPLETE:  nxt = IDLE;
            default:   nxt = IDLE;
        endcase
        if (bus.abort && state != IDLE) nxt = IDLE;
    end

    // Registered outputs, latched mask, channel index, flags and saturating counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q    <= '0;
            flags     <= '0;
            sel       <= '0;
            dcnt      <= '0;
            tcnt      <= '0;
            start_det <= 1'b0;
            sel_done  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            start_det <= state == TRIGGER && !bus.abort;
            sel_done  <= state == COMPLETE && !bus.abort;
            busy_q    <= nxt != IDLE;
            tcnt      <= state == WAIT_DONE ? ((&tcnt) ? tcnt : tcnt + 1'b1) : '0;
            dcnt      <= state == DELAY ? ((&dcnt) ? dcnt : dcnt + 1'b1) : '0;
            if (state == IDLE && bus.startSelector) begin
                mask_q <= bus.sensorMask;
                flags  <= '0;
                if (nfound) sel <= nidx;
            end
            if (state == WAIT_DONE && !bus.abort && !bus.detectionComplete && timed_out)
                flags[sel] <= 1'b1;
            if (state == DELAY && !bus.abort && delay_end && nfound)
                sel <= nidx;
        end
    end

    assign bus.startDetection   = start_det;
    assign bus.sensorSelect     = sel;
    assign bus.selectorComplete = sel_done;
    assign bus.busy             = busy_q;
    assign bus.timeoutFlags     = flags;
endmodule

// File: tb/tb_sensor_scan_sequencer.sv
// tb_sensor_scan_sequencer: table-driven scans with a select scoreboard plus abort/reset/timing sequences
module tb_sensor_scan_sequencer;
    import sensor_scan_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sensor_scan_if #(.NUM_SENSORS(12), .SEL_W(4)) bus ();

    sensor_scan_sequencer #(
        .NUM_SENSORS(12), .SEL_W(4), .DELAY_CYCLES(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [11:0] mask;
        logic [11:0] hang;
        int          delay;
        logic [11:0] flags;
        int          pulses;
    } vec_t;

    vec_t       tbl [8];
    int         errors = 0;
    int         checks = 0;
    int         pulses = 0;
    int         pend = 0;
    int         det_delay = 3;
    logic [11:0] hang_m = '0;
    logic [3:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Detector model: answers det_delay clocks after each pulse unless the channel hangs.
    initial begin
        bus.detectionComplete = 1'b0;
        forever begin
            @(negedge clk);
            bus.detectionComplete = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) bus.detectionComplete = 1'b1;
            end
            if (bus.startDetection && !hang_m[bus.sensorSelect]) pend = det_delay;
        end
    end

    // Scoreboard consumer: each startDetection pops the expected channel.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.startDetection) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got select %0d expected no pulse", bus.sensorSelect);
                end else begin
                    check("select", 32'(bus.sensorSelect), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic push_mask(input logic [11:0] m);
        for (int i = 0; i < 12; i++) if (m[i]) exp_q.push_back(4'(i));
    endtask

    task automatic run_scan(input vec_t v);
        bit done = 0;
        pend = 0;
        pulses = 0;
        hang_m = v.hang;
        det_delay = v.delay;
        push_mask(v.mask);
        bus.sensorMask = v.mask;
        bus.startSelector = 1'b1;
        @(posedge clk);
        #1;
        bus.startSelector = 1'b0;
        bus.sensorMask = ~v.mask;
        for (int c = 0; c < 2000 && !done; c++) begin
            @(negedge clk);
            if (c == 4 && v.mask != 0) bus.startSelector = 1'b1;
            if (c == 5) bus.startSelector = 1'b0;
            if (bus.selectorComplete) done = 1;
        end
        check("scan_done", 32'(done), 32'd1);
        check("pulse_count", 32'(pulses), 32'(v.pulses));
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        check("timeout_flags", 32'(bus.timeoutFlags), 32'(v.flags));
        check("busy_at_done", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("complete_one_clock", 32'(bus.selectorComplete), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        bit seen;
        int sc;
        tbl[0] = '{12'hFFF, 12'h000, 3,  12'h000, 12};
        tbl[1] = '{12'h821, 12'h000, 3,  12'h000, 3};
        tbl[2] = '{12'h00F, 12'h004, 3,  12'h004, 4};
        tbl[3] = '{12'h000, 12'h000, 3,  12'h000, 0};
        tbl[4] = '{12'h080, 12'h000, 15, 12'h000, 1};
        tbl[5] = '{12'h080, 12'h000, 16, 12'h080, 1};
        tbl[6] = '{12'h801, 12'h801, 3,  12'h801, 2};
        tbl[7] = '{12'h400, 12'h000, 1,  12'h000, 1};

        reset = 1'b1;
        bus.startSelector = 1'b1;
        bus.abort = 1'b1;
        bus.sensorMask = 12'hFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_start_det", 32'(bus.startDetection), 32'd0);
        check("rst_select", 32'(bus.sensorSelect), 32'd0);
        check("rst_complete", 32'(bus.selectorComplete), 32'd0);
        check("rst_flags", 32'(bus.timeoutFlags), 32'd0);
        bus.startSelector = 1'b0;
        bus.abort = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Empty mask: COMPLETE straight from IDLE, pulse two clocks after the request.
        bus.sensorMask = 12'h000;
        bus.startSelector = 1'b1;
        @(posedge clk);
        #1;
        bus.startSelector = 1'b0;
        @(negedge clk);
        check("empty_busy_complete_state", 32'(bus.busy), 32'd1);
        check("empty_no_early_complete", 32'(bus.selectorComplete), 32'd0);
        @(negedge clk);
        check("empty_complete_pulse", 32'(bus.selectorComplete), 32'd1);
        check("empty_busy_after", 32'(bus.busy), 32'd0);
        check("empty_no_start_det", 32'(pulses), 32'd0);
        repeat (2) @(negedge clk);

        for (int k = 0; k < 8; k++) run_scan(tbl[k]);

        // Abort while in DELAY after channel 4.
        pend = 0;
        hang_m = '0;
        det_delay = 3;
        pulses = 0;
        push_mask(12'h01F);
        bus.sensorMask = 12'h0FF;
        bus.startSelector = 1'b1;
        @(posedge clk);
        #1;
        bus.startSelector = 1'b0;
        seen = 0;
        for (int c = 0; c < 500 && !seen; c++) begin
            @(negedge clk);
            if (bus.startDetection && bus.sensorSelect == 4'd4) seen = 1;
        end
        check("abort_reach_ch4", 32'(seen), 32'd1);
        repeat (5) @(negedge clk);
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_start_det", 32'(bus.startDetection), 32'd0);
        sc = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.selectorComplete) sc++;
        end
        check("abort_no_complete", 32'(sc), 32'd0);
        check("abort_pulses", 32'(pulses), 32'd5);
        check("abort_sb_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        run_scan('{12'h0F0, 12'h000, 3, 12'h000, 4});

        // Reset in the middle of WAIT_DONE.
        pend = 0;
        hang_m = 12'h008;
        pulses = 0;
        push_mask(12'h008);
        bus.sensorMask = 12'h008;
        bus.startSelector = 1'b1;
        @(posedge clk);
        #1;
        bus.startSelector = 1'b0;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (bus.startDetection) seen = 1;
        end
        check("rstmid_pulse_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
        check("rstmid_select_before", 32'(bus.sensorSelect), 32'd3);
        reset = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        check("rstmid_busy", 32'(bus.busy), 32'd0);
        check("rstmid_select", 32'(bus.sensorSelect), 32'd0);
        check("rstmid_start_det", 32'(bus.startDetection), 32'd0);
        check("rstmid_complete", 32'(bus.selectorComplete), 32'd0);
        check("rstmid_flags", 32'(bus.timeoutFlags), 32'd0);
        reset = 1'b0;
        bus.abort = 1'b0;
        repeat (20) @(negedge clk);
        check("rstmid_stays_idle", 32'(bus.busy), 32'd0);
        check("rstmid_flags_later", 32'(bus.timeoutFlags), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
